// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - serialises two lane memory accesses onto one DCache port, lane A first.
// Optional performance counters are enabled with DMEM_ARB_PERF_EN.
module dmem_port_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqA,
    input  logic        wenA,
    input  logic [31:0] addrA,
    input  logic [31:0] wdataA,
    output logic [31:0] rdataA,
    input  logic        reqB,
    input  logic        wenB,
    input  logic [31:0] addrB,
    input  logic [31:0] wdataB,
    output logic [31:0] rdataB,
    input  logic        DReady,
    input  logic [31:0] DReadData,
    output logic        Den,
    output logic        DWen,
    output logic [31:0] DAddr,
    output logic [31:0] DWriteData,
    output logic        stall
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_dual,
    output logic [31:0] perf_wait
`endif
);

    typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B, DONE} state_t;

    state_t state, state_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            rdataA <= 32'd0;
            rdataB <= 32'd0;
        end else begin
            state <= state_next;
            if (state == SERVE_A && DReady && !wenA) rdataA <= DReadData;
            if (state == SERVE_B && DReady && !wenB) rdataB <= DReadData;
        end
    end

    // Request set is sampled only in IDLE; the pipeline holds it stable while stalled.
    always_comb begin
        state_next = state;
        Den        = 1'b0;
        DWen       = 1'b0;
        DAddr      = 32'd0;
        DWriteData = 32'd0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = reqA | reqB;
                if (reqA)      state_next = SERVE_A;
                else if (reqB) state_next = SERVE_B;
            end
            SERVE_A: begin
                stall      = 1'b1;
                Den        = 1'b1;
                DWen       = wenA;
                DAddr      = addrA;
                DWriteData = wdataA;
                if (DReady) state_next = reqB ? SERVE_B : DONE;
            end
            SERVE_B: begin
                stall      = 1'b1;
                Den        = 1'b1;
                DWen       = wenB;
                DAddr      = addrB;
                DWriteData = wdataB;
                if (DReady) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_dual <= 32'd0;
            perf_wait <= 32'd0;
        end else begin
            if (state == SERVE_A && DReady && reqB) perf_dual <= perf_dual + 32'd1;
            if ((state == SERVE_A || state == SERVE_B) && !DReady) perf_wait <= perf_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - randomized self-checking bench for dmem_port_arbiter against a transaction-level model.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqA, wenA, reqB, wenB;
    logic [31:0] addrA, wdataA, addrB, wdataB;
    logic [31:0] rdataA, rdataB;
    logic        DReady;
    logic [31:0] DReadData;
    logic        Den, DWen;
    logic [31:0] DAddr, DWriteData;
    logic        stall;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_dual, perf_wait;
`endif

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .reqA(reqA), .wenA(wenA), .addrA(addrA), .wdataA(wdataA), .rdataA(rdataA),
        .reqB(reqB), .wenB(wenB), .addrB(addrB), .wdataB(wdataB), .rdataB(rdataB),
        .DReady(DReady), .DReadData(DReadData),
        .Den(Den), .DWen(DWen), .DAddr(DAddr), .DWriteData(DWriteData),
        .stall(stall)
`ifdef DMEM_ARB_PERF_EN
        , .perf_dual(perf_dual), .perf_wait(perf_wait)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level model: a word memory plus expected lane results and event counts.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_ra, exp_rb;
    int unsigned exp_dual, exp_wait;
    logic [31:0] addr_pool [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf;
`ifdef DMEM_ARB_PERF_EN
        check("perf_dual", perf_dual, exp_dual);
        check("perf_wait", perf_wait, exp_wait);
`endif
    endtask

    // One pipeline memory instruction pair: IDLE cycle, served lanes in order, then DONE.
    task automatic txn(input bit ra, input bit rb, input bit wa, input bit wb,
                       input logic [31:0] aa, input logic [31:0] ab,
                       input logic [31:0] da, input logic [31:0] db,
                       input int wta, input int wtb);
        reqA = ra; wenA = wa; addrA = aa; wdataA = da;
        reqB = rb; wenB = wb; addrB = ab; wdataB = db;
        DReady = 1'($urandom_range(0, 1));
        DReadData = $urandom;
        @(negedge clk);
        check("idle_stall", stall, 32'(ra | rb));
        check("idle_den", Den, 0);
        next_cycle;
        if (!(ra | rb)) return;
        for (int l = 0; l < 2; l++) begin
            bit act, w;
            logic [31:0] a, d;
            int wt;
            act = (l == 0) ? ra : rb;
            if (!act) continue;
            w  = (l == 0) ? wa : wb;
            a  = (l == 0) ? aa : ab;
            d  = (l == 0) ? da : db;
            wt = (l == 0) ? wta : wtb;
            for (int c = 0; c <= wt; c++) begin
                DReady    = (c == wt);
                DReadData = DReady ? mem[a] : $urandom;
                @(negedge clk);
                check("serve_stall", stall, 1);
                check("serve_den", Den, 1);
                check("serve_dwen", DWen, 32'(w));
                check("serve_daddr", DAddr, a);
                check("serve_dwdata", DWriteData, d);
                if (!DReady) exp_wait++;
                if (DReady) begin
                    if (w) mem[a] = d;
                    else if (l == 0) exp_ra = mem[a];
                    else exp_rb = mem[a];
                end
                next_cycle;
            end
        end
        if (ra && rb) exp_dual++;
        DReady    = 1'($urandom_range(0, 1));
        DReadData = $urandom;
        @(negedge clk);
        check("done_stall", stall, 0);
        check("done_den", Den, 0);
        check("done_dwen", DWen, 0);
        check("done_daddr", DAddr, 0);
        check("done_dwdata", DWriteData, 0);
        check("rdataA", rdataA, exp_ra);
        check("rdataB", rdataB, exp_rb);
        check_perf();
        next_cycle;
    endtask

    initial begin
        addr_pool[0] = 32'h40; addr_pool[1] = 32'h44;
        addr_pool[2] = 32'h48; addr_pool[3] = 32'h100;
        for (int i = 0; i < 4; i++) mem[addr_pool[i]] = $urandom;
        exp_ra = 0; exp_rb = 0; exp_dual = 0; exp_wait = 0;

        reset = 1'b0;
        reqA = 0; wenA = 0; addrA = 0; wdataA = 0;
        reqB = 0; wenB = 0; addrB = 0; wdataB = 0;
        DReady = 0; DReadData = 0;
        next_cycle;
        next_cycle;
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_den", Den, 0);
        check("rst_rdataA", rdataA, 0);
        check("rst_rdataB", rdataB, 0);
        check_perf();
        next_cycle;
        reset = 1'b1;

        // Single load A, immediate ready.
        mem[32'h100] = 32'h1234;
        txn(1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 32'h0, 0, 0);
        check("single_load_a", rdataA, 32'h1234);

        // A store then B load, same address.
        txn(1, 1, 1, 0, 32'h40, 32'h40, 32'hAA, 32'h0, 0, 0);
        check("store_fwd_b", rdataB, 32'hAA);

        // B only with four wait cycles.
        txn(0, 1, 0, 0, 32'h0, 32'h44, 32'h0, 32'h0, 0, 4);

        // Two stores to one address: B's data is final.
        txn(1, 1, 1, 1, 32'h48, 32'h48, 32'h11, 32'h22, 1, 0);
        txn(0, 1, 0, 0, 32'h0, 32'h48, 32'h0, 32'h0, 0, 0);
        check("store_order", rdataB, 32'h22);

        // Back-to-back dual accesses.
        for (int i = 0; i < 3; i++)
            txn(1, 1, 0, 0, addr_pool[i], addr_pool[i+1], 32'h0, 32'h0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            int ia, ib;
            ia = $urandom_range(0, 3);
            ib = $urandom_range(0, 3);
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                addr_pool[ia], addr_pool[ib], $urandom, $urandom,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        // Reset while A is waiting on the cache.
        reqA = 1; wenA = 0; addrA = 32'h100; wdataA = 0;
        reqB = 0; DReady = 0;
        @(negedge clk);
        check("pre_rst_stall", stall, 1);
        next_cycle;
        @(negedge clk);
        check("pre_rst_den", Den, 1);
        reset = 1'b0;
        reqA  = 0;
        next_cycle;
        reset = 1'b1;
        exp_ra = 0; exp_rb = 0; exp_dual = 0; exp_wait = 0;
        @(negedge clk);
        check("mid_rst_den", Den, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_rdataA", rdataA, 0);
        check("mid_rst_rdataB", rdataB, 0);
        check_perf();
        next_cycle;

        txn(1, 1, 0, 0, 32'h100, 32'h44, 32'h0, 32'h0, 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
